// File: rtl/micro_hash_pkg.sv
// Shared constants, block layout and FSM state type for the micro-hash nonce search controller.
package micro_hash_pkg;

    localparam int unsigned BYTE         = 8;
    localparam int unsigned NONCE_OFFSET = 12;
    localparam int unsigned NONCE_W      = 32;
    localparam int unsigned PAYLOAD_W    = NONCE_OFFSET * BYTE;
    localparam int unsigned BLOCK_W      = 16 * BYTE;
    localparam int unsigned HASH_W       = 3 * BYTE;
    localparam int unsigned TIMEOUT_DEF  = 127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Nonce occupies the top word, payload bytes 0..11 the low 96 bits.
    typedef struct packed {
        logic [NONCE_W-1:0]   nonce;
        logic [PAYLOAD_W-1:0] payload;
    } hash_block_t;

endpackage

// File: rtl/micro_hash_nonce_search_if.sv
// Bus between the nonce search controller (master) and the micro-hash core (slave).
interface micro_hash_nonce_search_if;
    import micro_hash_pkg::*;

    logic [BLOCK_W-1:0] hash_block;
    logic               hash_next;
    logic               hash_finished;
    logic [HASH_W-1:0]  hash_h;
    logic               hash_valid;

    modport master (
        output hash_block,
        output hash_next,
        output hash_finished,
        input  hash_h,
        input  hash_valid
    );

    modport slave (
        input  hash_block,
        input  hash_next,
        input  hash_finished,
        output hash_h,
        output hash_valid
    );
endinterface

// File: rtl/micro_hash_target_cmp.sv
// Difficulty check: both upper hash bytes must be strictly below the target.
module micro_hash_target_cmp
    import micro_hash_pkg::*;
(
    input  logic [2*BYTE-1:0] hash_hi,
    input  logic [BYTE-1:0]   target,
    output logic              pass_c
);

    assign pass_c = (hash_hi[2*BYTE-1 -: BYTE] < target) && (hash_hi[BYTE-1 -: BYTE] < target);

endmodule

// File: rtl/micro_hash_nonce_search.sv
// Nonce search controller for the micro-hash core: one hash per nonce until a hit, exhaustion or timeout.
// Optional HASH_ATTEMPT_CNT_EN adds attempts/cycles statistics outputs.
module micro_hash_nonce_search
    import micro_hash_pkg::*;
#(
    parameter logic [NONCE_W-1:0] MAX_NONCE = 32'hFFFF_FFFF,
    parameter int unsigned        TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [BYTE-1:0]      target,
    micro_hash_nonce_search_if.master core,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 exhausted,
    output logic                 error,
    output logic [NONCE_W-1:0]   nonce_out,
    output logic [HASH_W-1:0]    hash_out
`ifdef HASH_ATTEMPT_CNT_EN
    ,
    output logic [31:0]          attempts,
    output logic [31:0]          cycles
`endif
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    state_t               state;
    logic [NONCE_W-1:0]   nonce_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [BYTE-1:0]      target_q;
    logic [TCNT_W-1:0]    tcnt_q;
    logic                 hash_next_q;
    logic                 hash_finished_q;
    logic                 pass_c;
    hash_block_t          block;

    assign block              = '{nonce: nonce_q, payload: payload_q};
    assign core.hash_block    = block;
    assign core.hash_next     = hash_next_q;
    assign core.hash_finished = hash_finished_q;

    // Pass check runs on the registered hash so CHECK sees the captured result.
    micro_hash_target_cmp u_cmp (
        .hash_hi (hash_out[HASH_W-1 -: 2*BYTE]),
        .target  (target_q),
        .pass_c  (pass_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_IDLE;
            nonce_q         <= '0;
            payload_q       <= '0;
            target_q        <= '0;
            tcnt_q          <= '0;
            hash_next_q     <= 1'b0;
            hash_finished_q <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            found           <= 1'b0;
            exhausted       <= 1'b0;
            error           <= 1'b0;
            nonce_out       <= '0;
            hash_out        <= '0;
`ifdef HASH_ATTEMPT_CNT_EN
            attempts        <= '0;
            cycles          <= '0;
`endif
        end else begin
            hash_next_q <= 1'b0;
            done        <= 1'b0;
`ifdef HASH_ATTEMPT_CNT_EN
            if (state == ST_LAUNCH) begin
                attempts <= attempts + 32'd1;
            end
            if (state inside {ST_LAUNCH, ST_WAIT, ST_CHECK}) begin
                cycles <= cycles + 32'd1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        payload_q       <= payload;
                        target_q        <= target;
                        nonce_q         <= '0;
                        found           <= 1'b0;
                        exhausted       <= 1'b0;
                        error           <= 1'b0;
                        busy            <= 1'b1;
                        hash_finished_q <= 1'b0;
                        hash_next_q     <= 1'b1;
                        state           <= ST_LAUNCH;
`ifdef HASH_ATTEMPT_CNT_EN
                        attempts        <= '0;
                        cycles          <= '0;
`endif
                    end
                end
                ST_LAUNCH: begin
                    tcnt_q <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core.hash_valid) begin
                        hash_out  <= core.hash_h;
                        nonce_out <= nonce_q;
                        state     <= ST_CHECK;
                    end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                        error           <= 1'b1;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        hash_finished_q <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (pass_c || (nonce_q == MAX_NONCE)) begin
                        found           <= pass_c;
                        exhausted       <= !pass_c;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        hash_finished_q <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        nonce_q     <= nonce_q + NONCE_W'(1);
                        hash_next_q <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_hash_nonce_search.sv
// Self-checking bench: stub hash core with programmable latency and per-nonce table, scoreboard of search results.
module tb_micro_hash_nonce_search;
    import micro_hash_pkg::*;

    typedef struct packed {
        logic        found;
        logic        exhausted;
        logic        error;
        logic        chk_data;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [31:0] launches;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [95:0] payload = '0;
    logic [7:0]  target = '0;
    logic        busy, done, found, exhausted, error;
    logic [31:0] nonce_out;
    logic [23:0] hash_out;
`ifdef HASH_ATTEMPT_CNT_EN
    logic [31:0] attempts, cycles;
`endif

    logic [23:0] hash_tbl [8];
    int unsigned stub_lat = 4;
    logic        stub_mute = 1'b0;
    logic        force_valid = 1'b0;
    logic [23:0] force_h = 24'h010203;
    logic        stub_valid = 1'b0;
    logic        stub_pend = 1'b0;
    logic [23:0] stub_h = '0;
    int unsigned stub_cnt = 0;
    logic [2:0]  stub_idx = '0;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   launch_cnt = 0;
    int   busy_cnt = 0;

    micro_hash_nonce_search_if ifc ();

    assign ifc.hash_valid = stub_valid | force_valid;
    assign ifc.hash_h     = force_valid ? force_h : stub_h;

    micro_hash_nonce_search #(
        .MAX_NONCE (32'd7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .payload   (payload),
        .target    (target),
        .core      (ifc),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .exhausted (exhausted),
        .error     (error),
        .nonce_out (nonce_out),
        .hash_out  (hash_out)
`ifdef HASH_ATTEMPT_CNT_EN
        ,
        .attempts  (attempts),
        .cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic f, input logic x, input logic er, input logic cd,
                                    input logic [31:0] n, input logic [23:0] h, input logic [31:0] l);
        exp_t e;
        e.found     = f;
        e.exhausted = x;
        e.error     = er;
        e.chk_data  = cd;
        e.nonce     = n;
        e.hash      = h;
        e.launches  = l;
        return e;
    endfunction

    // Stub core: answers each hash_next after stub_lat cycles with the table entry for that nonce.
    always @(posedge clk) begin
        stub_valid <= 1'b0;
        if (!reset) begin
            stub_pend <= 1'b0;
        end else if (ifc.hash_next && !stub_mute) begin
            stub_pend <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_idx  <= ifc.hash_block[98:96];
        end else if (stub_pend) begin
            if (stub_cnt <= 1) begin
                stub_valid <= 1'b1;
                stub_h     <= hash_tbl[stub_idx];
                stub_pend  <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Monitor: checks launched blocks and pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            launch_cnt = 0;
            busy_cnt   = 0;
        end else begin
            if (busy) busy_cnt++;
            if (ifc.hash_next) begin
                check("blk_nonce", 128'(ifc.hash_block[127:96]), 128'(launch_cnt));
                check("blk_payload", 128'(ifc.hash_block[95:0]), 128'(payload));
                launch_cnt++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("found", 128'(found), 128'(e.found));
                    check("exhausted", 128'(exhausted), 128'(e.exhausted));
                    check("error", 128'(error), 128'(e.error));
                    check("launches", 128'(launch_cnt), 128'(e.launches));
                    check("done_busy", 128'(busy), 128'(0));
                    check("done_hfin", 128'(ifc.hash_finished), 128'(1));
                    if (e.chk_data) begin
                        check("nonce_out", 128'(nonce_out), 128'(e.nonce));
                        check("hash_out", 128'(hash_out), 128'(e.hash));
                    end
`ifdef HASH_ATTEMPT_CNT_EN
                    check("attempts", 128'(attempts), 128'(e.launches));
                    check("cycles", 128'(cycles), 128'(busy_cnt));
`endif
                end
                launch_cnt = 0;
                busy_cnt   = 0;
            end
        end
    end

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic run_search(input logic [95:0] pl, input logic [7:0] tg, input exp_t e, input int budget);
        payload = pl;
        target  = tg;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(budget);
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) hash_tbl[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_found", 128'(found), 128'(0));
        check("rst_exh", 128'(exhausted), 128'(0));
        check("rst_err", 128'(error), 128'(0));
        check("rst_nonce", 128'(nonce_out), 128'(0));
        check("rst_hash", 128'(hash_out), 128'(0));
        check("rst_next", 128'(ifc.hash_next), 128'(0));
        check("rst_hfin", 128'(ifc.hash_finished), 128'(1));
        check("rst_block", 128'(ifc.hash_block), 128'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_hfin", 128'(ifc.hash_finished), 128'(1));
        check("idle_next", 128'(ifc.hash_next), 128'(0));

        // Immediate hit on nonce 0 with slow core
        hash_tbl[0] = 24'h0503AA;
        stub_lat    = 70;
        run_search(96'h0B0A_0908_0706_0504_0302_0100, 8'h10,
                   mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 24'h0503AA, 32'd1), 300);

        // Hit on the fourth nonce
        stub_lat = 5;
        for (int i = 0; i < 3; i++) hash_tbl[i] = 24'hFFFF00;
        hash_tbl[3] = 24'h010F00;
        run_search(96'hDEAD_BEEF_CAFE_F00D_1234_5678, 8'h10,
                   mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 24'h010F00, 32'd4), 300);

        // Near-miss hashes at the target boundary exhaust the range
        stub_lat    = 3;
        hash_tbl[0] = 24'h100000;
        hash_tbl[1] = 24'h001000;
        hash_tbl[2] = 24'hFF0000;
        hash_tbl[3] = 24'h00FF00;
        hash_tbl[4] = 24'h101010;
        hash_tbl[5] = 24'h0F1000;
        hash_tbl[6] = 24'h100F00;
        hash_tbl[7] = 24'h200000;
        run_search(96'h1111_2222_3333_4444_5555_6666, 8'h10,
                   mk_exp(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 24'h200000, 32'd8), 400);

        // target=0 can never pass
        for (int i = 0; i < 8; i++) hash_tbl[i] = '0;
        run_search(96'hA5A5_A5A5_5A5A_5A5A_0F0F_F0F0, 8'h00,
                   mk_exp(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 24'h000000, 32'd8), 400);

        // Held start relaunches straight after DONE
        hash_tbl[0] = 24'h000000;
        stub_lat    = 2;
        payload     = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
        target      = 8'h10;
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 24'h000000, 32'd1));
        sb.push_back(mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 24'h000000, 32'd1));
        start = 1'b1;
        wait_done(50);
        wait_done(50);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("relaunch_idle", 128'(busy), 128'(0));

        // Timeout: core never answers
        stub_mute = 1'b1;
        payload   = 96'hFEED_FACE_0000_1111_2222_3333;
        sb.push_back(mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 24'h0, 32'd1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_launch", 128'(ifc.hash_next), 128'(1));
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check("timeout_cycles", 128'(n - 1), 128'(127));
        check("timeout_err", 128'(error), 128'(1));
        check("timeout_found", 128'(found), 128'(0));
        @(negedge clk);

        // Start while busy is ignored; reset mid-WAIT aborts without done
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_start_ign", 128'(launch_cnt), 128'(1));
        check("wait_busy", 128'(busy), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_hfin", 128'(ifc.hash_finished), 128'(1));
        check("abort_done", 128'(done), 128'(0));
        check("abort_err", 128'(error), 128'(0));
        force_valid = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stale_hash", 128'(hash_out), 128'(0));
        check("stale_found", 128'(found), 128'(0));
        check("stale_busy", 128'(busy), 128'(0));
        check("stale_next", 128'(launch_cnt), 128'(0));
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule
